// File: rtl/window_filter_ctrl.sv
// window_filter_ctrl: frame-level control for the 3x3 window filter.
// Arms on a clean VS rise, latches per-frame config, selects the result from
// the filter's sort outputs, substitutes border pixels and checks geometry.
module window_filter_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 480,
  parameter int CNT_W      = 12
) (
  input  logic                  clk,
  input  logic                  reset_p,
  input  logic                  enable,
  input  logic [1:0]            cfg_mode,
  input  logic                  cfg_border_en,
  input  logic [DATA_WIDTH-1:0] cfg_border_val,
  input  logic [DATA_WIDTH-1:0] fil_min,
  input  logic [DATA_WIDTH-1:0] fil_mid,
  input  logic [DATA_WIDTH-1:0] fil_max,
  input  logic                  fil_valid,
  input  logic                  fil_hs,
  input  logic                  fil_vs,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_valid,
  output logic                  data_out_hs,
  output logic                  data_out_vs,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  err_line,
  output logic                  err_frame
);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_ACTIVE, S_DONE} state_t;

  localparam logic [CNT_W-1:0] W_C    = CNT_W'(IMG_W);
  localparam logic [CNT_W-1:0] H_C    = CNT_W'(IMG_H);
  localparam logic [CNT_W-1:0] W_LAST = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(IMG_H - 1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  state_t                  state_q, state_d;
  logic                    seen_low_q, seen_low_d;
  logic                    start;
  logic [CNT_W-1:0]        col_q, col_d, row_q, row_d;
  logic                    err_line_q, err_line_d, err_frame_q, err_frame_d;
  logic [1:0]              mode_q;
  logic                    ben_q;
  logic [DATA_WIDTH-1:0]   bval_q;
  logic                    hs_q;
  logic [DATA_WIDTH-1:0]   dout_q;
  logic                    vld_q, hs_o_q, vs_o_q, busy_q, done_q;

  // Effective per-cycle views: on the start cycle the fresh config and
  // cleared counters apply so a pixel on the VS-rise cycle is handled right.
  logic                    act, px, hs_fall, line_end, border;
  logic [CNT_W-1:0]        col_b, row_b;
  logic [1:0]              mode_e;
  logic                    ben_e;
  logic [DATA_WIDTH-1:0]   bval_e, res, pix;

  // Next-state logic; ARMED needs one sampled VS-low before a rise counts
  always_comb begin
    state_d    = state_q;
    seen_low_d = 1'b0;
    start      = 1'b0;
    case (state_q)
      S_IDLE:   if (enable) state_d = S_ARMED;
      S_ARMED: begin
        if (!enable) state_d = S_IDLE;
        else if (seen_low_q && fil_vs) begin
          state_d = S_ACTIVE;
          start   = 1'b1;
        end else seen_low_d = seen_low_q | ~fil_vs;
      end
      S_ACTIVE: if (!fil_vs) state_d = S_DONE;
      S_DONE:   state_d = enable ? S_ARMED : S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Position counters, geometry checks and result/border selection
  always_comb begin
    act      = (state_q == S_ACTIVE) | start;
    px       = fil_valid & fil_hs & fil_vs;
    col_b    = start ? '0 : col_q;
    row_b    = start ? '0 : row_q;
    mode_e   = start ? cfg_mode : mode_q;
    ben_e    = start ? cfg_border_en : ben_q;
    bval_e   = start ? cfg_border_val : bval_q;
    hs_fall  = hs_q & ~fil_hs;
    line_end = act & hs_fall & (col_b != '0);

    col_d       = col_q;
    row_d       = row_q;
    err_line_d  = start ? 1'b0 : err_line_q;
    err_frame_d = start ? 1'b0 : err_frame_q;
    if (act) begin
      col_d = col_b;
      row_d = row_b;
      if (px && col_b != '1) col_d = col_b + ONE;
      if (line_end) begin
        if (col_b != W_C) err_line_d = 1'b1;
        if (row_b != '1) row_d = row_b + ONE;
        col_d = '0;
      end
    end
    // row_d already includes a line closed in the same cycle as VS fall
    if (state_q == S_ACTIVE && state_d == S_DONE && row_d != H_C) err_frame_d = 1'b1;

    case (mode_e)
      2'd0:    res = fil_min;
      2'd1:    res = fil_mid;
      2'd2:    res = fil_max;
      default: res = fil_max - fil_min;
    endcase
    border = ben_e & ((row_b == '0) | (row_b == H_LAST) | (col_b == '0) | (col_b == W_LAST));
    pix    = border ? bval_e : res;
  end

  // State, counters, shadow config and registered outputs
  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state_q     <= S_IDLE;
      seen_low_q  <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      err_line_q  <= 1'b0;
      err_frame_q <= 1'b0;
      mode_q      <= '0;
      ben_q       <= 1'b0;
      bval_q      <= '0;
      hs_q        <= 1'b0;
      dout_q      <= '0;
      vld_q       <= 1'b0;
      hs_o_q      <= 1'b0;
      vs_o_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      seen_low_q  <= seen_low_d;
      col_q       <= col_d;
      row_q       <= row_d;
      err_line_q  <= err_line_d;
      err_frame_q <= err_frame_d;
      if (start) begin
        mode_q <= cfg_mode;
        ben_q  <= cfg_border_en;
        bval_q <= cfg_border_val;
      end
      hs_q   <= fil_hs;
      if (act && px) dout_q <= pix;
      vld_q  <= act & px;
      hs_o_q <= act & fil_hs;
      vs_o_q <= act & fil_vs;
      busy_q <= (state_d == S_ACTIVE);
      done_q <= (state_d == S_DONE);
    end
  end

  assign data_out       = dout_q;
  assign data_out_valid = vld_q;
  assign data_out_hs    = hs_o_q;
  assign data_out_vs    = vs_o_q;
  assign busy           = busy_q;
  assign frame_done     = done_q;
  assign err_line       = err_line_q;
  assign err_frame      = err_frame_q;

endmodule

// File: tb/tb_window_filter_ctrl.sv
// Bench for window_filter_ctrl with an 8x4 frame geometry. Frames are driven
// by (row, col) loops; each accepted pixel's expected output is computed from
// its position and the frame's latched config and queued with its due cycle.
module tb_window_filter_ctrl;
  localparam int W = 8;
  localparam int H = 4;

  logic       clk, reset_p, enable;
  logic [1:0] cfg_mode;
  logic       cfg_border_en;
  logic [7:0] cfg_border_val, fil_min, fil_mid, fil_max;
  logic       fil_valid, fil_hs, fil_vs;
  logic [7:0] data_out;
  logic       data_out_valid, data_out_hs, data_out_vs, busy, frame_done, err_line, err_frame;

  window_filter_ctrl #(.DATA_WIDTH(8), .IMG_W(W), .IMG_H(H), .CNT_W(12)) dut (
    .clk(clk), .reset_p(reset_p), .enable(enable), .cfg_mode(cfg_mode),
    .cfg_border_en(cfg_border_en), .cfg_border_val(cfg_border_val),
    .fil_min(fil_min), .fil_mid(fil_mid), .fil_max(fil_max),
    .fil_valid(fil_valid), .fil_hs(fil_hs), .fil_vs(fil_vs),
    .data_out(data_out), .data_out_valid(data_out_valid), .data_out_hs(data_out_hs),
    .data_out_vs(data_out_vs), .busy(busy), .frame_done(frame_done),
    .err_line(err_line), .err_frame(err_frame));

  typedef struct { int due; logic [7:0] d; } exp_t;
  exp_t q[$];

  int  n_chk = 0, n_err = 0;
  int  cyc = 0;
  int  out_cnt = 0, ff_cnt = 0, done_cnt = 0;
  bit  accept = 0;
  logic vs_s = 0, hs_s = 0, errf_done = 0;

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, a, e, cyc);
    end
  endtask

  // Expected pixel from position and the frame's latched config
  function automatic logic [7:0] expv(input logic [1:0] m, input bit ben, input logic [7:0] bv,
                                      input int r, input int c);
    if (ben && (r == 0 || r == H-1 || c == 0 || c == W-1)) return bv;
    case (m)
      2'd0: return fil_min;
      2'd1: return fil_mid;
      2'd2: return fil_max;
      default: return fil_max - fil_min;
    endcase
  endfunction

  always @(posedge clk) begin
    cyc  <= cyc + 1;
    vs_s <= fil_vs & accept;
    hs_s <= fil_hs & accept;
  end

  // Per-cycle compare against the queued expectations
  always @(negedge clk) begin
    if (!reset_p) begin
      if (q.size() > 0 && q[0].due < cyc) begin
        check("late_pixel", 32'(cyc), 32'(q[0].due));
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].due == cyc) begin
        check("valid", {31'd0, data_out_valid}, 32'd1);
        check("data", {24'd0, data_out}, {24'd0, q[0].d});
        void'(q.pop_front());
      end else begin
        check("no_valid", {31'd0, data_out_valid}, 32'd0);
      end
      check("vs_out", {31'd0, data_out_vs}, {31'd0, vs_s});
      check("hs_out", {31'd0, data_out_hs}, {31'd0, hs_s});
      if (data_out_valid) begin
        out_cnt++;
        if (data_out == 8'hFF) ff_cnt++;
      end
      if (frame_done) begin
        done_cnt++;
        errf_done = err_frame;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive_px(input logic [1:0] m, input bit ben, input logic [7:0] bv,
                          input int r, input int c);
    exp_t e;
    fil_hs = 1; fil_valid = 1;
    if (accept) begin
      e.due = cyc + 1;
      e.d   = expv(m, ben, bv, r, c);
      q.push_back(e);
    end
    step();
  endtask

  task automatic frame(input int lines, input int short_ln, input bit acc, input bit arm_late,
                       input bit tight, input int chg_ln, input logic [1:0] chg_m);
    logic [1:0] m; bit ben; logic [7:0] bv;
    m = cfg_mode; ben = cfg_border_en; bv = cfg_border_val;
    accept = acc; fil_vs = 1; fil_hs = 0; fil_valid = 0;
    step();
    if (arm_late) enable = 1;
    check("busy_at_vs", {31'd0, busy}, {31'd0, acc});
    fil_valid = 1; step();          // stray valid without HS must be ignored
    fil_valid = 0; step();
    for (int r = 0; r < lines; r++) begin
      if (r == chg_ln) cfg_mode = chg_m;
      for (int c = 0; c < ((r == short_ln) ? W-1 : W); c++) drive_px(m, ben, bv, r, c);
      fil_hs = 0; fil_valid = 0;
      if (!(tight && r == lines-1)) begin step(); step(); end
    end
    fil_vs = 0;
    repeat (4) step();
    accept = 0;
  endtask

  int n0, d0, f0;

  initial begin
    reset_p = 1; enable = 0; cfg_mode = 0; cfg_border_en = 0; cfg_border_val = 0;
    fil_min = 0; fil_mid = 0; fil_max = 0; fil_valid = 0; fil_hs = 0; fil_vs = 0;
    #1;
    check("rst_data", {24'd0, data_out}, 32'd0);
    check("rst_valid", {31'd0, data_out_valid}, 32'd0);
    check("rst_vs", {31'd0, data_out_vs}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, frame_done}, 32'd0);
    check("rst_errs", {30'd0, err_line, err_frame}, 32'd0);
    step(); step();
    reset_p = 0;
    step();
    enable = 1;
    step(); step();

    // nominal frame, mode min
    fil_min = 8'h10; fil_mid = 8'h20; fil_max = 8'h30;
    n0 = out_cnt; d0 = done_cnt;
    frame(4, -1, 1, 0, 0, -1, 2'd0);
    check("nom_count", 32'(out_cnt - n0), 32'd32);
    check("nom_done", 32'(done_cnt - d0), 32'd1);
    check("nom_err_line", {31'd0, err_line}, 32'd0);
    check("nom_err_frame", {31'd0, err_frame}, 32'd0);
    check("nom_last", {24'd0, data_out}, 32'h10);

    // gradient, mode write mid-frame deferred to next frame
    cfg_mode = 2'd3; fil_min = 8'h30; fil_mid = 8'h80; fil_max = 8'hF0;
    frame(4, -1, 1, 0, 0, 1, 2'd1);
    check("grad_last", {24'd0, data_out}, 32'hC0);
    frame(4, -1, 1, 0, 0, -1, 2'd0);
    check("mid_last", {24'd0, data_out}, 32'h80);

    // border substitution; last HS fall coincides with VS fall
    cfg_mode = 2'd0; fil_min = 8'h10; cfg_border_en = 1; cfg_border_val = 8'hFF;
    f0 = ff_cnt; n0 = out_cnt;
    frame(4, -1, 1, 0, 1, -1, 2'd0);
    check("border_ff", 32'(ff_cnt - f0), 32'd20);
    check("border_count", 32'(out_cnt - n0), 32'd32);
    check("tight_err_frame", {31'd0, err_frame}, 32'd0);
    cfg_border_en = 0;

    // arming while a frame is in progress skips that frame
    enable = 0;
    repeat (3) step();
    check("idle_busy", {31'd0, busy}, 32'd0);
    n0 = out_cnt; d0 = done_cnt;
    frame(4, -1, 0, 1, 0, -1, 2'd0);
    check("skip_count", 32'(out_cnt - n0), 32'd0);
    check("skip_done", 32'(done_cnt - d0), 32'd0);
    n0 = out_cnt; d0 = done_cnt;
    frame(4, -1, 1, 0, 0, -1, 2'd0);
    check("after_skip_count", 32'(out_cnt - n0), 32'd32);
    check("after_skip_done", 32'(done_cnt - d0), 32'd1);

    // geometry errors: short first line, 3-line frame
    frame(3, 0, 1, 0, 0, -1, 2'd0);
    check("geo_err_line", {31'd0, err_line}, 32'd1);
    check("geo_err_frame", {31'd0, err_frame}, 32'd1);
    check("geo_errf_at_done", {31'd0, errf_done}, 32'd1);
    repeat (3) step();
    check("geo_sticky", {30'd0, err_line, err_frame}, 32'd3);
    frame(4, -1, 1, 0, 0, -1, 2'd0);
    check("geo_cleared", {30'd0, err_line, err_frame}, 32'd0);

    // async reset during row 2
    accept = 1; fil_vs = 1; fil_hs = 0; fil_valid = 0;
    step(); step();
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c < W; c++) drive_px(2'd0, 0, 8'h00, r, c);
      fil_hs = 0; fil_valid = 0; step(); step();
    end
    for (int c = 0; c < 3; c++) drive_px(2'd0, 0, 8'h00, 2, c);
    reset_p = 1;
    #1;
    check("ar_valid", {31'd0, data_out_valid}, 32'd0);
    check("ar_data", {24'd0, data_out}, 32'd0);
    check("ar_sync", {29'd0, data_out_hs, data_out_vs, busy}, 32'd0);
    q.delete();
    accept = 0;
    @(posedge clk); #1;
    reset_p = 0;
    n0 = out_cnt; d0 = done_cnt;
    for (int c = 3; c < W; c++) drive_px(2'd0, 0, 8'h00, 2, c);
    fil_hs = 0; fil_valid = 0; step(); step();
    for (int c = 0; c < W; c++) drive_px(2'd0, 0, 8'h00, 3, c);
    fil_hs = 0; fil_valid = 0; step();
    check("ar_busy_vs_high", {31'd0, busy}, 32'd0);
    fil_vs = 0;
    repeat (4) step();
    check("ar_no_output", 32'(out_cnt - n0), 32'd0);
    check("ar_no_done", 32'(done_cnt - d0), 32'd0);

    // recovery after reset on a fresh VS rise
    n0 = out_cnt; d0 = done_cnt;
    frame(4, -1, 1, 0, 0, -1, 2'd0);
    check("rec_count", 32'(out_cnt - n0), 32'd32);
    check("rec_done", 32'(done_cnt - d0), 32'd1);
    check("rec_queue_empty", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/window_filter_ctrl.md
Name: window_filter_ctrl

Overview:
Frame-level controller for the 3x3 window filter datapath.
- Arms on a clean frame start and latches per-frame configuration at VS rise.
- Selects the result (min/mid/max/gradient) from the filter's three sort outputs.
- Tracks output column/row position, substitutes border pixels, and checks frame geometry.
- Sits directly downstream of the filter engine and feeds the video sink.

Parameters:
- DATA_WIDTH, 8: pixel width.
- IMG_W, 640: expected valid pixels per line.
- IMG_H, 480: expected lines per frame.
- CNT_W, 12: column/row counter width; must satisfy 2^CNT_W > max(IMG_W, IMG_H).

Ports:
- clk  in  1  pixel clock
- reset_p  in  1  asynchronous, active-high reset
- enable  in  1  level; 1 = process frames
- cfg_mode  in  2  0=min, 1=mid, 2=max, 3=max-min
- cfg_border_en  in  1  replace border pixels
- cfg_border_val  in  DATA_WIDTH  border replacement value
- fil_min  in  DATA_WIDTH  filter min result
- fil_mid  in  DATA_WIDTH  filter median result
- fil_max  in  DATA_WIDTH  filter max result
- fil_valid  in  1  filter result valid
- fil_hs  in  1  filter line-active
- fil_vs  in  1  filter frame-active
- data_out  out  DATA_WIDTH  processed pixel
- data_out_valid  out  1  pixel valid
- data_out_hs  out  1  line-active
- data_out_vs  out  1  frame-active
- busy  out  1  state is ACTIVE
- frame_done  out  1  one-cycle pulse at frame end
- err_line  out  1  sticky: line length != IMG_W
- err_frame  out  1  sticky: line count != IMG_H

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0, shadow config 0.
- Pixel qualifier: px = fil_valid & fil_hs & fil_vs.

FSM:
- IDLE: if enable -> ARMED.
- ARMED: wait for fil_vs==0 sampled, then on the 0->1 edge of fil_vs go to ACTIVE. A frame already in progress when arming is skipped entirely.
- ARMED -> IDLE if enable drops.
- ACTIVE: on fil_vs 1->0 -> DONE.
- Deasserting enable in ACTIVE does not abort; the frame completes.
- DONE (1 cycle): frame_done=1; go to ARMED if enable, else IDLE.

Config shadowing:
- cfg_mode, cfg_border_en and cfg_border_val are sampled into shadow registers only on the cycle the ARMED->ACTIVE transition fires.
- Mid-frame changes have no effect until the next frame.

Counters (ACTIVE only):
- col increments per px.
- On fil_hs 1->0 with col!=0: if col!=IMG_W, set err_line; then row++ and col=0.
- On entry to DONE: if row!=IMG_H, set err_frame.
- row and col are cleared on the ARMED->ACTIVE transition.
- err_line and err_frame are cleared only by reset_p or on the ARMED->ACTIVE transition.
- col/row saturate at all-ones (no wrap) on oversize input.

Datapath:
- Result per shadow mode: fil_min / fil_mid / fil_max / (fil_max - fil_min). Width is DATA_WIDTH; the difference cannot underflow because max>=min.
- Border condition, evaluated with pre-increment counters: shadow border_en & (row==0 | row==IMG_H-1 | col==0 | col==IMG_W-1).
- Border pixels are replaced by the shadow border_val.

Output timing:
- All outputs registered, latency 1 cycle from fil_*.
- data_out_valid = px delayed 1, only in ACTIVE.
- data_out_hs = fil_hs delayed 1, gated by ACTIVE.
- data_out_vs = fil_vs delayed 1, gated by ACTIVE.
- data_out holds its last value when not valid.
- Outside ACTIVE (IDLE/ARMED/DONE): data_out_valid, data_out_hs and data_out_vs are 0.

Edge cases:
- Reset mid-frame: immediately IDLE; the next frame is accepted only after a fresh VS rise.
- fil_valid without fil_hs or fil_vs is ignored.
- An HS fall with col==0 (empty line) does not count as a line.
- VS fall in the same cycle as an HS fall: the line is counted first, then err_frame is checked.

Test Plan:
- Nominal frame: IMG_W=8, IMG_H=4, mode=0, border_en=0; enable then 4x8 px frame with fil_min=0x10 -> 32 outputs of 0x10, each 1 cycle after input; frame_done pulses once; err_line=err_frame=0.
- Mode and gradient: mode=3, fil_max=0xF0, fil_min=0x30 -> data_out=0xC0; writing mode=1 mid-frame leaves the frame at 0xC0; the next frame outputs fil_mid.
- Border: border_en=1, border_val=0xFF, 8x4 frame -> rows 0 and 3 and cols 0 and 7 give 0xFF (20 pixels); the 12 interior pixels give the selected result.
- Mid-frame arm: enable asserted while fil_vs=1 -> no output valid for that frame; the following frame is processed fully and busy rises at its VS edge.
- Geometry errors: one line of 7 pixels -> err_line=1; frame of 3 lines -> err_frame=1 at DONE; both stay set through the next frame start clear.
- Async reset during ACTIVE row 2 -> outputs 0 within the same cycle, busy=0; a VS that is already high is ignored until the next VS rise.
